counter_up: RTL
===============

Name: counter_up

Overview:
- Up-counting companion to the lab-1 down counter: counts from 0 to a terminal value WIDTH.
- Rolls over with a one-cycle carry pulse when wrap mode is set; otherwise stops and holds a sticky done flag.
- Intended as the seconds/minutes stage building block of the lab clock/timer chain. A carry from one stage drives the ena input of the next stage.

Parameters:
- dw, 8, width of result and load_val in bits.
- WIDTH, 7, terminal count; legal range 1..2**dw-1. Elaboration fails if WIDTH > 2**dw-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low: reset=0 forces the reset state immediately, independent of clk.
- ena  input  1  count enable, sampled in RUN only.
- start  input  1  single-cycle request; IDLE or DONE -> RUN.
- clr  input  1  synchronous clear to 0 and IDLE.
- load  input  1  synchronous load of load_val.
- load_val  input  dw  value to load; saturated to WIDTH.
- wrap  input  1  1 = roll over at WIDTH; 0 = stop at WIDTH.
- result  output  dw  registered count.
- tc  output  1  combinational; 1 when result == WIDTH.
- carry  output  1  registered one-cycle pulse on rollover.
- done  output  1  registered; 1 while in DONE.
- busy  output  1  registered; 1 while in RUN.

Behaviour:
- Reset asserted (reset=0):
  - result=0, state=IDLE, carry=0, done=0, busy=0.
  - Takes effect asynchronously and overrides everything, including a count that is in progress.
  - Release is synchronous to the next rising clk edge.
- States:
  - IDLE: holding; result unchanged unless clr or load.
  - RUN: counting.
  - DONE: stopped at WIDTH (wrap=0 only).
- Per-edge priority when reset=1: clr > load > start > count.
- clr: result<=0, state<=IDLE, carry<=0. Wins over any simultaneous load or start.
- load (no clr):
  - result <= min(load_val, WIDTH); carry<=0; state unchanged.
  - Exception: in DONE, load also moves state to IDLE and clears done.
  - Load never produces carry, even if the loaded value is WIDTH.
- start (no clr/load):
  - From IDLE: go to RUN with result unchanged, so counting resumes from a preloaded value.
  - From DONE: result<=0, go to RUN.
  - Ignored in RUN.
- RUN with ena=1:
  - result < WIDTH: result<=result+1, carry<=0.
  - result == WIDTH and wrap=1: result<=0, carry<=1 for exactly that cycle, stay in RUN.
  - result == WIDTH and wrap=0: result holds WIDTH, state<=DONE, done<=1, carry<=0.
- RUN with ena=0: hold result, carry<=0.
- Latency:
  - result updates on the edge where ena is sampled high.
  - carry is high in the cycle following the edge at which result was WIDTH, aligned with result==0.
- Counting reaches WIDTH after WIDTH enabled edges. A full wrap period is WIDTH+1 enabled edges.
- wrap may change at any time; it is sampled only at the WIDTH boundary.
- Arithmetic is unsigned, dw bits. result never exceeds WIDTH, so it never overflows dw.
- busy=1 iff state==RUN; done=1 iff state==DONE; both are registered with the state.

Decomposition:
- Shared package counter_pkg holds:
  - typedef enum logic [1:0] {CNT_IDLE, CNT_RUN, CNT_DONE} cnt_state_t.
  - A constant for the reset count value (0), reusable by counter_down-style stages.
- No sub-module: a single always_ff for state/result/carry/done/busy plus a continuous tc compare.

Test Plan:
1. dw=8, WIDTH=7, wrap=1, ena=1, start pulse:
   - result must be 0,1,...,7,0,1.
   - carry high only in the cycle where result returns to 0.
   - tc high only while result==7.
2. WIDTH=7, wrap=0, run 8 enabled edges:
   - result stops at 7, done=1, busy=0, no carry.
   - A further start pulse gives result=0, busy=1.
3. load_val=200 with WIDTH=7: result=7, no carry. Next, load_val=3 in IDLE then start: counting continues 4,5,6,7.
4. clr, load=1 and start all in the same cycle while in RUN at result=5: result=0, state IDLE, busy=0.
5. Drive reset low mid-count (result=4) between clock edges:
   - Outputs go to result=0, carry=0, done=0, busy=0 immediately, without a clk edge.
   - After release, counting starts only after a start pulse.
6. ena toggling 1,0,1,0 in RUN from 6 with wrap=1: result 7,7,0,0 with a single carry pulse.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the lab clock/timer counter stages.
// Holds the stage state encoding and the common reset count value.
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_IDLE,
        CNT_RUN,
        CNT_DONE
    } cnt_state_t;

    localparam int CNT_RESET_VAL = 0;

endpackage

// File: rtl/counter_up.sv
// Up-counting timer stage: counts 0..WIDTH, then rolls over with a carry pulse or stops in DONE.
// The carry output is intended to feed the ena input of the next stage in the chain.
module counter_up
    import counter_pkg::*;
#(
    parameter int dw    = 8,
    parameter int WIDTH = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ena,
    input  logic          start,
    input  logic          clr,
    input  logic          load,
    input  logic [dw-1:0] load_val,
    input  logic          wrap,
    output logic [dw-1:0] result,
    output logic          tc,
    output logic          carry,
    output logic          done,
    output logic          busy
);

    generate
        if (WIDTH < 1 || WIDTH > (2**dw) - 1) begin : g_bad_width
            $error("counter_up: WIDTH must lie in 1..2**dw-1");
        end
    endgenerate

    localparam logic [dw-1:0] WIDTH_C = dw'(WIDTH);
    localparam logic [dw-1:0] ZERO_C  = dw'(CNT_RESET_VAL);

    cnt_state_t    state_reg, state_next;
    logic [dw-1:0] result_reg, result_next;
    logic          carry_reg, carry_next;
    logic          done_reg;
    logic          busy_reg;
    logic [dw-1:0] load_sat;

    assign load_sat = (load_val > WIDTH_C) ? WIDTH_C : load_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= CNT_IDLE;
            result_reg <= ZERO_C;
            carry_reg  <= 1'b0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            carry_reg  <= carry_next;
            done_reg   <= (state_next == CNT_DONE);
            busy_reg   <= (state_next == CNT_RUN);
        end
    end

    // Priority: clr > load > start > count. Carry defaults low so it only lasts one cycle.
    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        carry_next  = 1'b0;
        if (clr) begin
            result_next = ZERO_C;
            state_next  = CNT_IDLE;
        end else if (load) begin
            result_next = load_sat;
            if (state_reg == CNT_DONE) begin
                state_next = CNT_IDLE;
            end
        end else if (start && state_reg != CNT_RUN) begin
            if (state_reg == CNT_DONE) begin
                result_next = ZERO_C;
            end
            state_next = CNT_RUN;
        end else if (state_reg == CNT_RUN && ena) begin
            if (result_reg < WIDTH_C) begin
                result_next = result_reg + dw'(1);
            end else if (wrap) begin
                result_next = ZERO_C;
                carry_next  = 1'b1;
            end else begin
                state_next = CNT_DONE;
            end
        end
    end

    assign result = result_reg;
    assign tc     = (result_reg == WIDTH_C);
    assign carry  = carry_reg;
    assign done   = done_reg;
    assign busy   = busy_reg;

endmodule
